// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_det_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam int unsigned MASK_W = 32;

  // Mask with the low 'len' bits set; callers narrow it to their pattern width.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    if (len >= MASK_W) return '1;
    return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/seq_detector_prog_if.sv
// Configuration, serial-input and status bundle of the sequence detector.
interface seq_detector_prog_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in_bit;
  logic               out_match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               busy;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
    input  out_match, match_count, cfg_err, busy
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
    output out_match, match_count, cfg_err, busy
  );
endinterface

// File: rtl/seq_det_history.sv
// Bit history shift register with a saturating count of bits held.
// o_hist_n / o_fill_n present the values as they will be once the current bit is taken.
module seq_det_history #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic               i_bit,
  input  logic               i_fill_clr,
  output logic [MAX_LEN-1:0] o_hist_n,
  output logic [LEN_W-1:0]   o_fill_n
);
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;

  // Look-ahead history and fill level including the incoming bit.
  always_comb begin
    o_hist_n = {r_hist[MAX_LEN-2:0], i_bit};
    o_fill_n = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  end

  // Commit shifted history; a match in non-overlap mode restarts the fill count.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= o_hist_n;
      r_fill <= i_fill_clr ? '0 : o_fill_n;
    end
  end
endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-sequence detector: run-time pattern/length/overlap,
// registered one-cycle match pulse and saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_detector_prog_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  state_t             r_state;
  state_t             w_state_n;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_match;
  logic [CNT_W-1:0]   r_count;
  logic               r_err;

  logic               w_legal;
  logic               w_shift;
  logic               w_match;
  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;

  assign w_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  // Bits arriving alongside a cfg_load are dropped.
  assign w_shift = (r_state == ST_RUN) && bus.in_valid && !bus.cfg_load;
  assign w_mask  = MAX_LEN'(len_mask(32'(r_len)));

  seq_det_history #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_history (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (bus.cfg_load),
    .i_shift   (w_shift),
    .i_bit     (bus.in_bit),
    .i_fill_clr(w_match && !r_overlap),
    .o_hist_n  (w_hist_n),
    .o_fill_n  (w_fill_n)
  );

  // Match when enough bits are held and the newest len bits equal the pattern.
  always_comb begin
    w_match = 1'b0;
    if (w_shift && (w_fill_n >= r_len) && (((w_hist_n ^ r_pattern) & w_mask) == '0))
      w_match = 1'b1;
  end

  // FSM next state: any load decides RUN vs IDLE by length legality.
  always_comb begin
    w_state_n = r_state;
    if (bus.cfg_load) w_state_n = w_legal ? ST_RUN : ST_IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_n;
  end

  // Configuration storage and sticky length-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_err     <= 1'b0;
    end else if (bus.cfg_load) begin
      r_err <= !w_legal;
      if (w_legal) begin
        r_pattern <= bus.cfg_pattern;
        r_len     <= bus.cfg_len;
        r_overlap <= bus.cfg_overlap;
      end
    end
  end

  // Registered match pulse and saturating match counter.
  always_ff @(posedge clk) begin
    if (rst || bus.cfg_load) begin
      r_match <= 1'b0;
      r_count <= '0;
    end else begin
      r_match <= w_match;
      if (w_match && (r_count != '1)) r_count <= r_count + CNT_W'(1);
    end
  end

  assign bus.out_match   = r_match;
  assign bus.match_count = r_count;
  assign bus.cfg_err     = r_err;
  assign bus.busy        = (r_state == ST_RUN);
endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: two instances (8-bit and 2-bit counters) share
// stimulus; expectations come from a bit-queue model of the detection rules.
module tb_seq_detector_prog;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(8)) bus8 ();
  seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(2)) bus2 ();

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit       m_run, m_err, m_ov, m_match;
  bit [7:0] m_pat;
  int       m_len;
  bit       m_q[$];
  int       m_cnt8, m_cnt2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".match8"}, 32'(bus8.out_match), 32'(m_match));
    chk({tag, ".match2"}, 32'(bus2.out_match), 32'(m_match));
    chk({tag, ".count8"}, 32'(bus8.match_count), 32'(m_cnt8));
    chk({tag, ".count2"}, 32'(bus2.match_count), 32'(m_cnt2));
    chk({tag, ".err"}, 32'(bus8.cfg_err), 32'(m_err));
    chk({tag, ".busy"}, 32'(bus8.busy), 32'(m_run));
  endtask

  // Model: remember received bits; a match is the last len bits equal to the
  // pattern read MSB-first. Non-overlap forgets everything after a match.
  task automatic model(input bit ld, input bit [7:0] pat, input int len, input bit ov,
                       input bit v, input bit b);
    bit hit;
    m_match = 1'b0;
    if (ld) begin
      m_err = (len < 1) || (len > 8);
      m_run = !m_err;
      if (!m_err) begin m_pat = pat; m_len = len; m_ov = ov; end
      m_q.delete();
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (m_run && v) begin
      m_q.push_back(b);
      if (m_q.size() > 8) void'(m_q.pop_front());
      if (m_q.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_q[m_q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
        if (hit) begin
          m_match = 1'b1;
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
          if (!m_ov) m_q.delete();
        end
      end
    end
  endtask

  task automatic step(input string tag, input bit ld, input bit [7:0] pat, input int len,
                      input bit ov, input bit v, input bit b);
    bus8.cfg_load = ld;  bus2.cfg_load = ld;
    bus8.cfg_pattern = pat;  bus2.cfg_pattern = pat;
    bus8.cfg_len = 4'(len);  bus2.cfg_len = 4'(len);
    bus8.cfg_overlap = ov;  bus2.cfg_overlap = ov;
    bus8.in_valid = v;  bus2.in_valid = v;
    bus8.in_bit = b;  bus2.in_bit = b;
    model(ld, pat, len, ov, v, b);
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic load(input string tag, input bit [7:0] pat, input int len, input bit ov);
    step(tag, 1'b1, pat, len, ov, 1'b1, 1'b1);
  endtask

  task automatic send(input string tag, input bit v, input bit b);
    step(tag, 1'b0, 8'h00, 0, 1'b0, v, b);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus8.cfg_load = 1'b0;  bus2.cfg_load = 1'b0;
    bus8.in_valid = 1'b1;  bus2.in_valid = 1'b1;
    bus8.in_bit = 1'b1;  bus2.in_bit = 1'b1;
    m_run = 0; m_err = 0; m_match = 0; m_cnt8 = 0; m_cnt2 = 0; m_q.delete();
    @(posedge clk);
    #1;
    chk_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    bit s1[7] = '{1, 1, 0, 1, 1, 0, 1};
    bus8.cfg_load = 0; bus8.cfg_pattern = '0; bus8.cfg_len = '0; bus8.cfg_overlap = 0;
    bus8.in_valid = 0; bus8.in_bit = 0;
    bus2.cfg_load = 0; bus2.cfg_pattern = '0; bus2.cfg_len = '0; bus2.cfg_overlap = 0;
    bus2.in_valid = 0; bus2.in_bit = 0;
    do_reset("reset");

    // 1) non-overlap 1101
    load("t1.load", 8'b1101, 4, 1'b0);
    foreach (s1[i]) send("t1.bit", 1'b1, s1[i]);
    send("t1.idle", 1'b0, 1'b0);

    // 2) overlap 1101
    load("t2.load", 8'b1101, 4, 1'b1);
    foreach (s1[i]) send("t2.bit", 1'b1, s1[i]);
    send("t2.idle", 1'b0, 1'b0);

    // 3) illegal lengths, then legal
    load("t3.len0", 8'hFF, 0, 1'b1);
    repeat (4) send("t3.idle0", 1'b1, 1'b1);
    load("t3.len9", 8'hFF, 9, 1'b1);
    repeat (4) send("t3.idle9", 1'b1, 1'b1);
    load("t3.legal", 8'b1, 1, 1'b1);

    // 4) len=1 with gaps
    load("t4.load", 8'b1, 1, 1'b1);
    repeat (5) begin
      send("t4.bit", 1'b1, 1'b1);
      send("t4.gap", 1'b0, 1'b1);
    end

    // 5) counter saturation on the 2-bit instance
    load("t5.load", 8'b11, 2, 1'b1);
    repeat (10) send("t5.bit", 1'b1, 1'b1);

    // 6) reset and reload during a partial match
    load("t6.load", 8'b1101, 4, 1'b0);
    send("t6.b1", 1'b1, 1'b1);
    send("t6.b2", 1'b1, 1'b1);
    send("t6.b3", 1'b1, 1'b0);
    do_reset("t6.rst");
    send("t6.after", 1'b1, 1'b1);
    load("t6.reload", 8'b1101, 4, 1'b0);
    send("t6.c1", 1'b1, 1'b1);
    send("t6.c2", 1'b1, 1'b1);
    send("t6.c3", 1'b1, 1'b0);
    load("t6.reload2", 8'b1101, 4, 1'b0);
    send("t6.c4", 1'b1, 1'b1);

    // Randomized configurations and streams
    for (int c = 0; c < 12; c++) begin
      int len;
      if ($urandom_range(0, 5) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 15));
      else len = int'($urandom_range(1, (c < 6) ? 3 : 8));
      load("rnd.load", 8'($urandom), len, 1'($urandom));
      for (int i = 0; i < 40; i++)
        send("rnd.bit", ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
